// File: rtl/mips_run_ctrl_pkg.sv
// Shared types for the MIPS run controller: session state and mode encodings.
package mips_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_SWAIT,
    ST_SEXEC,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_BOUNDED     = 2'b00,
    MODE_FREE        = 2'b01,
    MODE_STEP        = 2'b10,
    MODE_BOUNDED_ALT = 2'b11
  } mode_t;

endpackage

// File: rtl/mips_run_ctrl_down_cnt.sv
// Loadable down counter with zero flag; stops at zero instead of wrapping.
module runctl_down_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for MIPS cores: reset hold, bounded/free-run/single-step sessions.
// Optional heartbeat watchdog enabled by defining RUNCTL_WDOG_EN.
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned RUN_CYCLES   = 20,
  parameter int unsigned WDOG_CYCLES  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 step,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] core_en_mask,
  input  logic [CNT_W-1:0]     run_budget,
  output logic [NUM_CORES-1:0] core_reset,
  output logic [NUM_CORES-1:0] core_clk_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count
`ifdef RUNCTL_WDOG_EN
  ,
  input  logic [NUM_CORES-1:0] heartbeat,
  output logic                 wdog_trip
`endif
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

  state_t               state, nxt;
  logic [NUM_CORES-1:0] mask_q;
  logic [1:0]           mode_q;
  logic                 load;
  logic                 hold_zero;
  logic                 budget_zero;
  logic                 executing;
  logic                 wdog_hit;
  logic [CNT_W-1:0]     eff_budget;

  assign load       = (state == ST_IDLE) && start;
  assign executing  = (state == ST_RUN) || (state == ST_SEXEC);
  assign eff_budget = (run_budget == '0) ? CNT_W'(RUN_CYCLES) : run_budget;

  // Counters are loaded with N-1 so the zero flag marks the last cycle of the phase.
  runctl_down_cnt #(.W(HOLD_W)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (HOLD_W'(RESET_CYCLES - 1)),
    .dec      (state == ST_HOLD),
    .zero     (hold_zero)
  );

  runctl_down_cnt #(.W(CNT_W)) u_budget (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (eff_budget - 1'b1),
    .dec      (executing),
    .zero     (budget_zero)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_HOLD;
      ST_HOLD: begin
        if (abort)          nxt = ST_DONE;
        else if (hold_zero) nxt = (mode_q == MODE_STEP) ? ST_SWAIT : ST_RUN;
      end
      ST_RUN: begin
        if (abort || wdog_hit)                      nxt = ST_DONE;
        else if (mode_q != MODE_FREE && budget_zero) nxt = ST_DONE;
      end
      ST_SWAIT: begin
        if (abort)     nxt = ST_DONE;
        else if (step) nxt = ST_SEXEC;
      end
      ST_SEXEC: nxt = (abort || wdog_hit || budget_zero) ? ST_DONE : ST_SWAIT;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      mode_q      <= '0;
      core_reset  <= '1;
      core_clk_en <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= nxt;
      busy        <= (nxt != ST_IDLE);
      done        <= (nxt == ST_DONE);
      core_clk_en <= (nxt == ST_RUN || nxt == ST_SEXEC) ? mask_q : '0;
      core_reset  <= (nxt == ST_IDLE || nxt == ST_HOLD) ? '1 : ~mask_q;
      if (load) begin
        mask_q      <= core_en_mask;
        mode_q      <= mode;
        cycle_count <= '0;
      end else if (executing && cycle_count != '1) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

`ifdef RUNCTL_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0]      wd_cnt [NUM_CORES];
  logic [NUM_CORES-1:0] wd_expire;

  always_comb begin
    wd_expire = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      wd_expire[i] = mask_q[i] && !heartbeat[i] && (wd_cnt[i] == WD_W'(WDOG_CYCLES - 1));
    end
  end

  assign wdog_hit = executing && (|wd_expire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_trip <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) wd_cnt[i] <= '0;
    end else if (load) begin
      wdog_trip <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) wd_cnt[i] <= '0;
    end else if (executing) begin
      if (wdog_hit && !abort) wdog_trip <= 1'b1;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (heartbeat[i] || !mask_q[i])  wd_cnt[i] <= '0;
        else if (wd_cnt[i] != '1)        wd_cnt[i] <= wd_cnt[i] + 1'b1;
      end
    end
  end
`else
  // WDOG_CYCLES stays a parameter so instantiations are identical in both builds.
  assign wdog_hit = 1'b0 & (WDOG_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed self-checking bench for mips_run_ctrl (two cores, plus a narrow-counter instance).
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, step, abort;
  logic [1:0]  mode, mask;
  logic [15:0] budget;
  logic [1:0]  core_reset, clk_en;
  logic        busy, done;
  logic [15:0] count;

  logic        start2, abort2, step2;
  logic [1:0]  mode2;
  logic [0:0]  mask2;
  logic [3:0]  budget2;
  logic [0:0]  rst2, en2;
  logic        busy2, done2;
  logic [3:0]  count2;

`ifdef RUNCTL_WDOG_EN
  logic [1:0]  hb;
  logic [0:0]  hb2;
  logic        wdog_trip, wdog_trip2;
`endif

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .NUM_CORES(2), .CNT_W(16), .RESET_CYCLES(5), .RUN_CYCLES(20), .WDOG_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .step(step), .abort(abort),
    .core_en_mask(mask), .run_budget(budget), .core_reset(core_reset),
    .core_clk_en(clk_en), .busy(busy), .done(done), .cycle_count(count)
`ifdef RUNCTL_WDOG_EN
    , .heartbeat(hb), .wdog_trip(wdog_trip)
`endif
  );

  mips_run_ctrl #(
    .NUM_CORES(1), .CNT_W(4), .RESET_CYCLES(5), .RUN_CYCLES(10), .WDOG_CYCLES(8)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .mode(mode2), .step(step2), .abort(abort2),
    .core_en_mask(mask2), .run_budget(budget2), .core_reset(rst2),
    .core_clk_en(en2), .busy(busy2), .done(done2), .cycle_count(count2)
`ifdef RUNCTL_WDOG_EN
    , .heartbeat(hb2), .wdog_trip(wdog_trip2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tallies one session from the current sample up to the done pulse (bounded).
  task automatic observe(output int hold_n, output int en0_n, output int en1_n,
                         output int rst0_low);
    hold_n = 0; en0_n = 0; en1_n = 0; rst0_low = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (busy && core_reset == 2'b11 && clk_en == 2'b00) hold_n++;
      if (clk_en[0]) en0_n++;
      if (clk_en[1]) en1_n++;
      if (!core_reset[0]) rst0_low++;
      tick();
    end
    chk("session_done", 32'(done), 32'd1);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int h, e0, e1, r0;
    reset = 1'b1; start = 0; step = 0; abort = 0; mode = 0; mask = 0; budget = 0;
    start2 = 0; abort2 = 0; step2 = 0; mode2 = 0; mask2 = 0; budget2 = 0;
`ifdef RUNCTL_WDOG_EN
    hb = 2'b11; hb2 = 1'b1;
`endif
    #2 reset = 1'b0;
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'h3);
    chk("rst_clk_en", 32'(clk_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    start = 1'b1;
    tick();
    tick();
    chk("rst_start_ignored", 32'(busy), 32'h0);
    start = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();

    // 1: bounded, default budget
    mode = 2'b00; mask = 2'b01; budget = 16'd0;
    kick();
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_count_clr", 32'(count), 32'h0);
    observe(h, e0, e1, r0);
    chk("t1_hold", 32'(h), 32'd5);
    chk("t1_en0", 32'(e0), 32'd20);
    chk("t1_en1", 32'(e1), 32'd0);
    chk("t1_count", 32'(count), 32'd20);
    chk("t1_done_rst", 32'(core_reset), 32'h2);
    chk("t1_done_en", 32'(clk_en), 32'h0);
    tick();
    chk("t1_idle_done", 32'(done), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_rst", 32'(core_reset), 32'h3);
    repeat (3) tick();
    chk("t1_count_hold", 32'(count), 32'd20);

    // 2: free-run, abort during 37th run cycle
    mode = 2'b01; mask = 2'b01; budget = 16'd0;
    kick();
    chk("t2_count_clr", 32'(count), 32'h0);
    mode = 2'b00;
    repeat (5) tick();
    chk("t2_run_en", 32'(clk_en), 32'h1);
    repeat (36) tick();
    chk("t2_pre_abort", 32'(count), 32'd36);
    chk("t2_no_budget_end", 32'(clk_en), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_count", 32'(count), 32'd37);
    chk("t2_done_busy", 32'(busy), 32'h1);
    tick();
    chk("t2_busy_drop", 32'(busy), 32'h0);

    // 3: single-step, budget 3, step during HOLD ignored
    mode = 2'b10; mask = 2'b01; budget = 16'd3;
    kick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (4) tick();
    chk("t3_swait_en", 32'(clk_en), 32'h0);
    chk("t3_swait_rst", 32'(core_reset), 32'h2);
    chk("t3_swait_count", 32'(count), 32'h0);
    for (int s = 0; s < 3; s++) begin
      repeat (2) tick();
      chk("t3_wait_en", 32'(clk_en), 32'h0);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("t3_sexec_en", 32'(clk_en), 32'h1);
      chk("t3_sexec_count", 32'(count), 32'(s));
      tick();
      chk("t3_after_en", 32'(clk_en), 32'h0);
      chk("t3_after_done", 32'(done), (s == 2) ? 32'h1 : 32'h0);
    end
    chk("t3_count", 32'(count), 32'd3);
    tick();
    chk("t3_idle", 32'(busy), 32'h0);

    // 4: channel 0 masked out
    mode = 2'b00; mask = 2'b10; budget = 16'd4;
    kick();
    observe(h, e0, e1, r0);
    chk("t4_hold", 32'(h), 32'd5);
    chk("t4_en0", 32'(e0), 32'd0);
    chk("t4_en1", 32'(e1), 32'd4);
    chk("t4_rst0_low", 32'(r0), 32'd0);
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_done_rst", 32'(core_reset), 32'h1);
    tick();

    // mode 11 behaves as bounded
    mode = 2'b11; mask = 2'b11; budget = 16'd2;
    kick();
    observe(h, e0, e1, r0);
    chk("m3_en0", 32'(e0), 32'd2);
    chk("m3_en1", 32'(e1), 32'd2);
    chk("m3_count", 32'(count), 32'd2);
    tick();

    // abort while still in HOLD
    mode = 2'b00; mask = 2'b01; budget = 16'd0;
    kick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("hab_done", 32'(done), 32'h1);
    chk("hab_count", 32'(count), 32'h0);
    chk("hab_en", 32'(clk_en), 32'h0);
    tick();
    chk("hab_idle", 32'(busy), 32'h0);

    // 5: start while busy ignored, async reset mid-RUN
    mode = 2'b01; mask = 2'b01;
    kick();
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_busy_start_en", 32'(clk_en), 32'h1);
    chk("t5_busy_start_cnt", 32'(count), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_core_reset", 32'(core_reset), 32'h3);
    chk("t5_rst_en", 32'(clk_en), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_count", 32'(count), 32'h0);
    @(negedge clk) reset = 1'b1;
    tick();
    tick();
    chk("t5_no_done", 32'(done), 32'h0);
    chk("t5_idle", 32'(busy), 32'h0);

    // cycle_count saturation on a 4-bit instance
    mode2 = 2'b01; mask2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (5) tick();
    chk("sat_run_en", 32'(en2), 32'h1);
    repeat (19) tick();
    chk("sat_count", 32'(count2), 32'hF);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    chk("sat_done", 32'(done2), 32'h1);
    chk("sat_done_count", 32'(count2), 32'hF);
    tick();
    chk("sat_idle", 32'(busy2), 32'h0);

`ifdef RUNCTL_WDOG_EN
    // 6: heartbeat stuck low trips the watchdog after 8 run cycles
    mode = 2'b00; mask = 2'b01; budget = 16'd0; hb = 2'b00;
    kick();
    observe(h, e0, e1, r0);
    chk("t6_en0", 32'(e0), 32'd8);
    chk("t6_trip", 32'(wdog_trip), 32'h1);
    tick();
    hb = 2'b11;
    kick();
    chk("t6_trip_clr", 32'(wdog_trip), 32'h0);
    observe(h, e0, e1, r0);
    chk("t6_hb_ok_en0", 32'(e0), 32'd20);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
